// File: rtl/audio_mem_pkg.sv
// audio_mem_pkg: shared types and constants for the audio SDRAM region
package audio_mem_pkg;

    localparam int ADDR_W           = 25;
    localparam int TIMER_W          = 7;
    localparam logic [24:0] AUDIO_BASE = 25'h80000;
    localparam int FIFO_DEPTH_WORDS = 1700;

    typedef enum logic [2:0] {
        IDLE,
        AUD_REQ,
        AUD_WAIT,
        AUD_ACK,
        LD_REQ,
        LD_ACK
    } bridge_state_t;

endpackage

// File: rtl/audio_sdram_bridge_if.sv
// audio_sdram_bridge_if: Avalon-MM master bus between the bridge and the SDRAM controller
interface audio_sdram_bridge_if #(
    parameter int ADDR_W = 25
);

    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [15:0]       avm_writedata;
    logic [1:0]        avm_byteenable;
    logic [15:0]       avm_readdata;
    logic              avm_readdatavalid;
    logic              avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_readdata, avm_readdatavalid, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_readdata, avm_readdatavalid, avm_waitrequest
    );

endinterface

// File: rtl/audio_sdram_bridge.sv
// audio_sdram_bridge: arbitrates streamer reads and loader writes onto one SDRAM Avalon-MM port
module audio_sdram_bridge #(
    parameter int ADDR_W  = audio_mem_pkg::ADDR_W,
    parameter int TIMEOUT = 64,
    parameter int ORPH_W  = 2
) (
    input  logic              Clk50,
    input  logic              reset,
    input  logic              init_done,
    input  logic              aud_rd,
    input  logic [ADDR_W-1:0] aud_addr,
    output logic [15:0]       aud_data,
    output logic              aud_ac,
    output logic              aud_wait,
    input  logic              ld_session,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_data,
    output logic              ld_ack,
    output logic              timeout_err,
    audio_sdram_bridge_if.master avm
);

    import audio_mem_pkg::*;

    bridge_state_t        state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [ORPH_W-1:0]    orph_q, orph_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [15:0]          wdata_q, wdata_d;
    logic [15:0]          aud_data_q, aud_data_d;
    logic                 timeout_q, timeout_d;
    logic                 aud_wait_q, aud_wait_d;
    logic                 orph_inc, orph_dec;

    assign avm.avm_address    = addr_q;
    assign avm.avm_writedata  = wdata_q;
    assign avm.avm_byteenable = 2'b11;
    assign avm.avm_read       = (state_q == AUD_REQ);
    assign avm.avm_write      = (state_q == LD_REQ);
    assign aud_ac             = (state_q == AUD_ACK);
    assign ld_ack             = (state_q == LD_ACK);
    assign aud_data           = aud_data_q;
    assign aud_wait           = aud_wait_q;
    assign timeout_err        = timeout_q;

    // State and datapath registers; reset returns everything to idle values
    always_ff @(posedge Clk50) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            orph_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            aud_data_q <= '0;
            timeout_q  <= 1'b0;
            aud_wait_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            orph_q     <= orph_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            aud_data_q <= aud_data_d;
            timeout_q  <= timeout_d;
            aud_wait_q <= aud_wait_d;
        end
    end

    // Next state: reads win in IDLE; a timed-out read leaves one orphan response to swallow later
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        aud_data_d = aud_data_q;
        timeout_d  = timeout_q;
        orph_inc   = 1'b0;
        orph_dec   = avm.avm_readdatavalid && (orph_q != '0);
        case (state_q)
            IDLE: begin
                if (aud_rd) begin
                    addr_d  = aud_addr;
                    state_d = AUD_REQ;
                end else if (ld_wr && ld_session) begin
                    addr_d  = ld_addr;
                    wdata_d = ld_data;
                    state_d = LD_REQ;
                end
            end
            AUD_REQ: begin
                if (!avm.avm_waitrequest) begin
                    timer_d = '0;
                    state_d = AUD_WAIT;
                end
            end
            AUD_WAIT: begin
                if (avm.avm_readdatavalid && (orph_q == '0)) begin
                    aud_data_d = avm.avm_readdata;
                    state_d    = AUD_ACK;
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    aud_data_d = '0;
                    timeout_d  = 1'b1;
                    orph_inc   = 1'b1;
                    state_d    = AUD_ACK;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            AUD_ACK: state_d = IDLE;
            LD_REQ:  state_d = avm.avm_waitrequest ? LD_REQ : LD_ACK;
            LD_ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        orph_d = (orph_inc && !orph_dec && (orph_q != '1)) ? orph_q + 1'b1
               : (orph_dec && !orph_inc) ? orph_q - 1'b1 : orph_q;
        aud_wait_d = ~init_done | ld_session;
    end

endmodule

// File: tb/tb_audio_sdram_bridge.sv
// tb_audio_sdram_bridge: directed vector table plus hand sequences for timeout and reset corners
module tb_audio_sdram_bridge;

    localparam int TO = 64;

    logic        Clk50 = 1'b0;
    logic        reset = 1'b1;
    logic        init_done = 1'b0;
    logic        aud_rd = 1'b0;
    logic [24:0] aud_addr = '0;
    logic [15:0] aud_data;
    logic        aud_ac;
    logic        aud_wait;
    logic        ld_session = 1'b0;
    logic        ld_wr = 1'b0;
    logic [24:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic        ld_ack;
    logic        timeout_err;
    int          pass_cnt = 0;
    int          tot_cnt = 0;

    audio_sdram_bridge_if #(.ADDR_W(25)) avm_bus ();

    audio_sdram_bridge #(.ADDR_W(25), .TIMEOUT(TO), .ORPH_W(2)) dut (
        .Clk50       (Clk50),
        .reset       (reset),
        .init_done   (init_done),
        .aud_rd      (aud_rd),
        .aud_addr    (aud_addr),
        .aud_data    (aud_data),
        .aud_ac      (aud_ac),
        .aud_wait    (aud_wait),
        .ld_session  (ld_session),
        .ld_wr       (ld_wr),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ack      (ld_ack),
        .timeout_err (timeout_err),
        .avm         (avm_bus)
    );

    always #10 Clk50 = ~Clk50;

    typedef struct {
        logic [4:0]  in;
        logic [24:0] ra;
        logic [24:0] la;
        logic [15:0] ldat;
        logic [15:0] rdat;
        logic [61:0] exp;
    } vec_t;

    vec_t tbl[$];

    // in = {aud_rd, ld_session, ld_wr, waitrequest, readdatavalid}
    // ctl = {avm_read, avm_write, aud_ac, ld_ack, aud_wait}
    function automatic vec_t mk(input logic [4:0] in, input logic [24:0] ra, input logic [24:0] la,
                                input logic [15:0] ldat, input logic [15:0] rdat, input logic [4:0] ctl,
                                input logic [24:0] eaddr, input logic [15:0] edata, input logic [15:0] ewd);
        vec_t v;
        v.in   = in;
        v.ra   = ra;
        v.la   = la;
        v.ldat = ldat;
        v.rdat = rdat;
        v.exp  = {ctl, eaddr, edata, ewd};
        return v;
    endfunction

    task automatic step();
        @(negedge Clk50);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else pass_cnt++;
    endtask

    initial begin
        int n;
        avm_bus.avm_readdata      = '0;
        avm_bus.avm_readdatavalid = 1'b0;
        avm_bus.avm_waitrequest   = 1'b0;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("reset_state%0d", i),
                64'({avm_bus.avm_read, avm_bus.avm_write, aud_ac, ld_ack, aud_wait, timeout_err,
                     avm_bus.avm_address, aud_data, avm_bus.avm_writedata}),
                64'({6'b000010, 25'h0, 16'h0, 16'h0}));
        end
        chk("byteenable", 64'(avm_bus.avm_byteenable), 64'(2'b11));
        init_done = 1'b1;
        step();
        chk("aud_wait_after_init", 64'(aud_wait), 64'(1'b0));

        tbl.push_back(mk(5'b10000, 25'h80000, '0, '0, '0, 5'b10000, 25'h80000, '0, '0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(5'b10000, 25'h80000, '0, '0, '0, 5'b00000, 25'h80000, '0, '0));
        tbl.push_back(mk(5'b10001, 25'h80000, '0, '0, 16'hA5C3, 5'b00100, 25'h80000, 16'hA5C3, '0));
        tbl.push_back(mk(5'b10000, 25'h80000, '0, '0, '0, 5'b00000, 25'h80000, 16'hA5C3, '0));
        tbl.push_back(mk(5'b00000, '0, '0, '0, '0, 5'b00000, 25'h80000, 16'hA5C3, '0));
        tbl.push_back(mk(5'b10010, 25'h80004, '0, '0, '0, 5'b10000, 25'h80004, 16'hA5C3, '0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(5'b10010, '0, '0, '0, '0, 5'b10000, 25'h80004, 16'hA5C3, '0));
        tbl.push_back(mk(5'b10000, '0, '0, '0, '0, 5'b00000, 25'h80004, 16'hA5C3, '0));
        tbl.push_back(mk(5'b10001, '0, '0, '0, 16'h5A5A, 5'b00100, 25'h80004, 16'h5A5A, '0));
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk(5'b00000, '0, '0, '0, '0, 5'b00000, 25'h80004, 16'h5A5A, '0));
        tbl.push_back(mk(5'b11100, 25'h80020, 25'h80010, 16'h1234, '0, 5'b10001, 25'h80020, 16'h5A5A, '0));
        tbl.push_back(mk(5'b11100, 25'h80020, 25'h80010, 16'h1234, '0, 5'b00001, 25'h80020, 16'h5A5A, '0));
        tbl.push_back(mk(5'b11101, 25'h80020, 25'h80010, 16'h1234, 16'hBEEF, 5'b00101, 25'h80020, 16'hBEEF, '0));
        tbl.push_back(mk(5'b01100, '0, 25'h80010, 16'h1234, '0, 5'b00001, 25'h80020, 16'hBEEF, '0));
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk(5'b01110, '0, 25'h80010, 16'h1234, '0, 5'b01001, 25'h80010, 16'hBEEF, 16'h1234));
        tbl.push_back(mk(5'b01100, '0, 25'h80010, 16'h1234, '0, 5'b00011, 25'h80010, 16'hBEEF, 16'h1234));
        tbl.push_back(mk(5'b01000, '0, '0, '0, '0, 5'b00001, 25'h80010, 16'hBEEF, 16'h1234));
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk(5'b00100, '0, 25'h80030, 16'h9999, '0, 5'b00000, 25'h80010, 16'hBEEF, 16'h1234));
        tbl.push_back(mk(5'b00000, '0, '0, '0, '0, 5'b00000, 25'h80010, 16'hBEEF, 16'h1234));
        tbl.push_back(mk(5'b00001, '0, '0, '0, 16'h1111, 5'b00000, 25'h80010, 16'hBEEF, 16'h1234));

        for (int i = 0; i < tbl.size(); i++) begin
            {aud_rd, ld_session, ld_wr, avm_bus.avm_waitrequest, avm_bus.avm_readdatavalid} = tbl[i].in;
            aud_addr             = tbl[i].ra;
            ld_addr              = tbl[i].la;
            ld_data              = tbl[i].ldat;
            avm_bus.avm_readdata = tbl[i].rdat;
            step();
            chk($sformatf("vec%0d", i),
                64'({avm_bus.avm_read, avm_bus.avm_write, aud_ac, ld_ack, aud_wait,
                     avm_bus.avm_address, aud_data, avm_bus.avm_writedata}),
                64'(tbl[i].exp));
        end
        {aud_rd, ld_session, ld_wr, avm_bus.avm_waitrequest, avm_bus.avm_readdatavalid} = 5'b00000;

        aud_rd   = 1'b1;
        aud_addr = 25'h80040;
        step();
        step();
        n = 0;
        while (!aud_ac && n < 200) begin
            step();
            n++;
        end
        chk("timeout_cycles", 64'(n), 64'(TO));
        chk("timeout_data", 64'(aud_data), 64'(16'h0000));
        chk("timeout_err_set", 64'(timeout_err), 64'(1'b1));
        aud_rd = 1'b0;
        step();
        chk("timeout_ac_single", 64'(aud_ac), 64'(1'b0));

        aud_rd   = 1'b1;
        aud_addr = 25'h80044;
        step();
        chk("next_read_addr", 64'({avm_bus.avm_read, avm_bus.avm_address}), 64'({1'b1, 25'h80044}));
        step();
        avm_bus.avm_readdatavalid = 1'b1;
        avm_bus.avm_readdata      = 16'hDEAD;
        step();
        chk("orphan_discarded", 64'({aud_ac, aud_data}), 64'({1'b0, 16'h0000}));
        avm_bus.avm_readdata = 16'h0F0F;
        step();
        chk("own_data", 64'({aud_ac, aud_data}), 64'({1'b1, 16'h0F0F}));
        avm_bus.avm_readdatavalid = 1'b0;
        aud_rd = 1'b0;
        step();
        chk("timeout_err_sticky", 64'({aud_ac, timeout_err}), 64'({1'b0, 1'b1}));

        aud_rd   = 1'b1;
        aud_addr = 25'h80050;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        chk("mid_reset", 64'({aud_ac, timeout_err, avm_bus.avm_read, aud_wait, aud_data}),
            64'({4'b0001, 16'h0000}));
        reset = 1'b0;
        step();
        chk("post_reset_req", 64'({avm_bus.avm_read, avm_bus.avm_address}), 64'({1'b1, 25'h80050}));
        step();
        avm_bus.avm_readdatavalid = 1'b1;
        avm_bus.avm_readdata      = 16'h3C3C;
        step();
        chk("post_reset_read", 64'({aud_ac, aud_data}), 64'({1'b1, 16'h3C3C}));
        avm_bus.avm_readdatavalid = 1'b0;
        aud_rd = 1'b0;
        step();
        chk("post_reset_idle", 64'({aud_ac, avm_bus.avm_read, aud_data}), 64'({2'b00, 16'h3C3C}));

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
